shift_right_seq: RTL
====================

Name: shift_right_seq

Overview:
- Iterative right shifter for the ALU datapath; performs the reverse of the upper-half immediate load.
- Shifting an operand right by N/2 moves its upper half into the lower half.
- Supports logical (zero fill) and arithmetic (sign fill) right shifts, one bit position per clock.
- Operands are accepted through a start/ready handshake; completion is flagged by a one-cycle done pulse.

Parameters:
- N, 8, operand/result width in bits; must be ≥2.
- SW, $clog2(N), width of the shift-amount port.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when ready=1.
- A  in  N  operand to shift.
- shamt  in  SW  shift amount, 0..N-1.
- arith  in  1  0 = logical (zero fill), 1 = arithmetic (replicate A[N-1]).
- ready  out  1  high in IDLE; block can accept start.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse; C is valid from this cycle on.
- C  out  N  registered result; holds its value until the next done.

Behaviour:
- Reset, asynchronous and active-high:
  - state=IDLE, C=0, done=0, busy=0, ready=1.
  - Internal shift register, counter and mode bit are cleared.
- Internal state: data register D[N-1:0], counter CNT[SW-1:0], latched fill bit F.
  - F = arith & A[N-1], captured when start is accepted.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: ready=1. On start=1:
    - D<=A, CNT<=shamt, F latched.
    - If shamt==0: C<=A and go to DONE.
    - Otherwise go to SHIFT.
  - SHIFT: busy=1, ready=0. Every cycle D<={F, D[N-1:1]} and CNT<=CNT-1.
    - When CNT==1 this cycle: C<={F, D[N-1:1]} and go to DONE.
  - DONE: done=1 for exactly one cycle; unconditionally return to IDLE.
- Latency: with start sampled at edge k, done is high in the cycle after edge k+shamt.
  - This is shamt+1 cycles after start; total time is N cycles worst case.
- start while ready=0 (SHIFT or DONE) is ignored; there is no queueing.
  - A, shamt and arith are don't-care outside the start-accept cycle.
- C changes only on entry to DONE or on reset. It is stable between done pulses.
- Back-to-back operation: start asserted in the IDLE cycle right after DONE is accepted.
  - Minimum issue interval is shamt+2 cycles.
- Reset asserted mid-operation aborts immediately. No done pulse is generated for the aborted request.
- Functional equivalence at done:
  - arith=0: C = A >> shamt.
  - arith=1: C = $signed(A) >>> shamt.
  - shamt=N/2, arith=0: C = {N/2 zeros, A[N-1:N/2]}.
- Exactly one done pulse per accepted start.
- done, busy and ready are mutually exclusive; at any time exactly one of IDLE/SHIFT/DONE is indicated.

Test Plan:
- Logical shift: N=8, A=8'hB4, shamt=4, arith=0, start 1 cycle.
  - busy high 4 cycles, then done pulse with C=8'h0B; ready returns the following cycle.
- Arithmetic shift: A=8'hB4, shamt=4, arith=1.
  - done after 5 cycles with C=8'hFB.
  - Repeat with A=8'h74: C=8'h07.
- Zero and maximum shift:
  - shamt=0, A=8'h5A: done the cycle after start, C=8'h5A.
  - shamt=7, A=8'h80, arith=1: C=8'hFF after 8 cycles.
  - shamt=7, A=8'h80, arith=0: C=8'h01 after 8 cycles.
- Ignored start: start with shamt=3, then pulse start again with A=8'hFF during busy.
  - Exactly one done with the first result.
  - C stays unchanged until a new start is accepted from IDLE.
- Reset mid-op: start with shamt=6, assert rst in the 3rd SHIFT cycle.
  - Outputs go to C=0, ready=1, done=0 immediately; no done follows.
  - A new request after reset completes correctly.
- Random regression: 500 random {A, shamt, arith} with back-to-back starts.
  - C matches the >>/>>> reference model.
  - done count equals accepted-start count.

Source files
------------

// File: rtl/shift_right_seq.sv
// Iterative right shifter: logical or arithmetic shift by shamt, one bit per clock.
// Operands enter through a start/ready handshake; a one-cycle done pulse marks a valid C.
module shift_right_seq #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  A,
    input  logic [SW-1:0] shamt,
    input  logic          arith,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  C
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  d_q, d_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          f_q, f_d;
    logic [N-1:0]  c_q, c_d;
    logic [N-1:0]  shifted;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == SW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            IDLE:    ready = 1'b1;
            SHIFT:   busy  = 1'b1;
            DONE:    done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Fill bit enters at the top; it is zero for logical shifts or positive operands.
    assign shifted = {f_q, d_q[N-1:1]};

    always_comb begin
        d_d   = d_q;
        cnt_d = cnt_q;
        f_d   = f_q;
        c_d   = c_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d   = A;
                    cnt_d = shamt;
                    f_d   = arith & A[N-1];
                    if (shamt == '0) begin
                        c_d = A;
                    end
                end
            end
            SHIFT: begin
                d_d   = shifted;
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    c_d = shifted;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q   <= '0;
            cnt_q <= '0;
            f_q   <= 1'b0;
            c_q   <= '0;
        end else begin
            d_q   <= d_d;
            cnt_q <= cnt_d;
            f_q   <= f_d;
            c_q   <= c_d;
        end
    end

    assign C = c_q;

endmodule
